conv_frame_sequencer: RTL and testbench

- Control block for one processing_element-based 3x3 convolution lane.
- Loads the kernel weights serially into a held weights_flat register.
- Accepts one frame of raster-order pixels and marks which pixel positions produce a complete window.
- Tracks the PE pipeline latency so it can tag each result with valid and output coordinates, then flushes and signals frame completion.

---
 rtl/conv_frame_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_conv_frame_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_sequencer.sv
// -----------------------------------------------------------------------------
// conv_frame_sequencer
//
// Control block for a single 3x3 (NKX x NKY) convolution lane built around a
// processing element. It loads the kernel serially into weights_flat, takes
// one raster-order frame of pixels, and flags which pixels complete a window.
// It then delays that flag through a PE_LATENCY-stage tag pipeline so every PE
// result carries a valid bit and output coordinates. Once the last result has
// drained it pulses done.
//
// Optional feature (compile-time macro CONV_PERF_CNT_EN):
//   adds stall_cnt, the number of RUN cycles with pix_valid low, saturating.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle pulse, begins weight load + frame (IDLE only)
//   busy            high whenever the sequencer is not idle
//   done            one-cycle pulse at end of frame
//   w_valid/w_data  weight stream, slot order k = 0..NKX*NKY-1
//   w_ready         high only while loading weights
//   weights_flat    held kernel, slot k at [k*PIX_WIDTH +: PIX_WIDTH]
//   pix_valid       input pixel strobe
//   pix_ready       high only while accepting pixels
//   win_valid       registered, window presented to the PE is complete
//   res_valid       PE result register holds a valid output
//   res_row/res_col output coordinates of the current result (held otherwise)
//   stall_cnt       (CONV_PERF_CNT_EN only) idle RUN cycle count
// -----------------------------------------------------------------------------
module conv_frame_sequencer #(
  parameter int unsigned IMG_W      = 64,
  parameter int unsigned IMG_H      = 64,
  parameter int unsigned PIX_WIDTH  = 16,
  parameter int unsigned NKX        = 3,
  parameter int unsigned NKY        = 3,
  parameter int unsigned PE_LATENCY = 3,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  input  logic                           w_valid,
  input  logic [PIX_WIDTH-1:0]           w_data,
  output logic                           w_ready,
  output logic [NKX*NKY*PIX_WIDTH-1:0]   weights_flat,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  output logic                           win_valid,
  output logic                           res_valid,
  output logic [CNT_WIDTH-1:0]           res_row,
  output logic [CNT_WIDTH-1:0]           res_col
`ifdef CONV_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]           stall_cnt
`endif
);

  localparam int unsigned NK = NKX * NKY;
  localparam int unsigned KW = (NK > 1) ? $clog2(NK + 1) : 1;
  localparam int unsigned FW = $clog2(PE_LATENCY + 2);

  localparam logic [KW-1:0]        KLast    = KW'(NK - 1);
  localparam logic [KW-1:0]        KOne     = KW'(1);
  localparam logic [FW-1:0]        FLast    = FW'(PE_LATENCY);
  localparam logic [FW-1:0]        FOne     = FW'(1);
  localparam logic [CNT_WIDTH-1:0] CntOne   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] ColLast  = CNT_WIDTH'(IMG_W - 1);
  localparam logic [CNT_WIDTH-1:0] RowLast  = CNT_WIDTH'(IMG_H - 1);
  localparam logic [CNT_WIDTH-1:0] ColFirst = CNT_WIDTH'(NKX - 1);
  localparam logic [CNT_WIDTH-1:0] RowFirst = CNT_WIDTH'(NKY - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StRun,
    StFlush,
    StDone
  } state_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q;
  logic [CNT_WIDTH-1:0] col_q, row_q;
  logic [FW-1:0]        fl_q;

  // Tag pipeline: index 0 is the window register, index PE_LATENCY the result.
  logic [PE_LATENCY:0]  sv_q;
  logic [CNT_WIDTH-1:0] sr_q [PE_LATENCY+1];
  logic [CNT_WIDTH-1:0] sc_q [PE_LATENCY+1];

  logic start_acc, w_acc, pix_acc, last_w, last_pix, flush_end, win_hit;

  // w_ready/pix_ready are registered decodes of the state, so they are exact
  // qualifiers for acceptance in the current state.
  assign start_acc = (state_q == StIdle) && start;
  assign w_acc     = w_valid && w_ready;
  assign pix_acc   = pix_valid && pix_ready;
  assign last_w    = w_acc && (k_q == KLast);
  assign last_pix  = pix_acc && (row_q == RowLast) && (col_q == ColLast);
  assign flush_end = (state_q == StFlush) && (fl_q == FLast);
  assign win_hit   = pix_acc && (row_q >= RowFirst) && (col_q >= ColFirst);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start)     state_d = StLoadW;
      StLoadW: if (last_w)    state_d = StRun;
      StRun:   if (last_pix)  state_d = StFlush;
      StFlush: if (flush_end) state_d = StDone;
      StDone:                 state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  // FSM, registered status outputs and frame counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      busy      <= 1'b0;
      w_ready   <= 1'b0;
      pix_ready <= 1'b0;
      done      <= 1'b0;
      k_q       <= '0;
      col_q     <= '0;
      row_q     <= '0;
      fl_q      <= '0;
    end else begin
      state_q   <= state_d;
      busy      <= (state_d != StIdle);
      w_ready   <= (state_d == StLoadW);
      pix_ready <= (state_d == StRun);
      done      <= (state_d == StDone);

      if (start_acc) begin
        k_q <= '0;
      end else if (w_acc) begin
        k_q <= k_q + KOne;
      end

      if (start_acc) begin
        col_q <= '0;
        row_q <= '0;
      end else if (pix_acc) begin
        if (col_q == ColLast) begin
          col_q <= '0;
          row_q <= row_q + CntOne;
        end else begin
          col_q <= col_q + CntOne;
        end
      end

      // Counts FLUSH cycles; PE_LATENCY+1 of them drain the tag pipeline.
      if (state_q == StFlush) begin
        fl_q <= fl_q + FOne;
      end else begin
        fl_q <= '0;
      end
    end
  end

  // Kernel register: written only on accepted weights, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weights_flat <= '0;
    end else if (w_acc) begin
      for (int s = 0; s < NK; s++) begin
        if (k_q == KW'(s)) begin
          weights_flat[s*PIX_WIDTH +: PIX_WIDTH] <= w_data;
        end
      end
    end
  end

  // Window flag and tag pipeline. The pipeline advances every cycle so input
  // bubbles appear as res_valid=0 slots rather than stalling results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sv_q <= '0;
      for (int i = 0; i <= PE_LATENCY; i++) begin
        sr_q[i] <= '0;
        sc_q[i] <= '0;
      end
    end else begin
      sv_q[0] <= win_hit;
      if (win_hit) begin
        sr_q[0] <= row_q - RowFirst;
        sc_q[0] <= col_q - ColFirst;
      end
      for (int i = 1; i <= PE_LATENCY; i++) begin
        sv_q[i] <= sv_q[i-1];
        // Final stage only loads valid tags so res_row/res_col hold between results.
        if ((i < PE_LATENCY) || sv_q[i-1]) begin
          sr_q[i] <= sr_q[i-1];
          sc_q[i] <= sc_q[i-1];
        end
      end
    end
  end

  assign win_valid = sv_q[0];
  assign res_valid = sv_q[PE_LATENCY];
  assign res_row   = sr_q[PE_LATENCY];
  assign res_col   = sc_q[PE_LATENCY];

`ifdef CONV_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if ((state_q == StRun) && !pix_valid && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CntOne;
    end
  end
`endif

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Testbench for conv_frame_sequencer (8x8 frame, 3x3 kernel, PE_LATENCY=3).
module tb_conv_frame_sequencer;

  localparam int W   = 8;
  localparam int H   = 8;
  localparam int P   = 3;
  localparam int PW  = 16;
  localparam int CW  = 16;
  localparam int KX  = 3;
  localparam int KY  = 3;
  localparam int NK  = KX * KY;
  localparam int NOUT = (W - KX + 1) * (H - KY + 1);

  localparam int PIdle = 0, PLoad = 1, PRun = 2, PFlush = 3, PDone = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic w_valid = 1'b0;
  logic [PW-1:0] w_data = '0;
  logic pix_valid = 1'b0;
  logic busy, done, w_ready, pix_ready, win_valid, res_valid;
  logic [NK*PW-1:0] weights_flat;
  logic [CW-1:0] res_row, res_col;
`ifdef CONV_PERF_CNT_EN
  logic [CW-1:0] stall_cnt;
`endif

  conv_frame_sequencer #(
    .IMG_W(W), .IMG_H(H), .PIX_WIDTH(PW), .NKX(KX), .NKY(KY),
    .PE_LATENCY(P), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .weights_flat(weights_flat), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .win_valid(win_valid), .res_valid(res_valid), .res_row(res_row), .res_col(res_col)
`ifdef CONV_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: phase, weight slot, raster pixel index, flush count.
  typedef struct {
    int due;
    int r;
    int c;
  } res_t;
  res_t q[$];
  int m_ph, m_k, m_n, m_f, m_stall;
  bit m_win;
  logic [NK*PW-1:0] m_wf;
  int last_r, last_c;

  // Per-frame observations.
  int obs_res, obs_done, obs_last_r, obs_last_c, obs_first, obs_first_r, obs_first_c;
  int done_cyc, last_acc_cyc, acc22_cyc;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_ph = PIdle; m_k = 0; m_n = 0; m_f = 0; m_stall = 0; m_win = 0;
    m_wf = '0; q.delete(); last_r = 0; last_c = 0;
  endtask

  task automatic clear_obs();
    obs_res = 0; obs_done = 0; obs_last_r = -1; obs_last_c = -1;
    obs_first = -1; obs_first_r = -1; obs_first_c = -1;
    done_cyc = -1; last_acc_cyc = -1; acc22_cyc = -1;
  endtask

  // One clock: update the model with the inputs seen at the edge, then check.
  task automatic step();
    int r, c;
    bit exp_rv;
    res_t e;
    @(posedge clk);
    cyc++;
    m_win = 0;
    if (rst) begin
      model_clear();
    end else begin
      case (m_ph)
        PIdle: if (start) begin m_ph = PLoad; m_k = 0; m_stall = 0; end
        PLoad: if (w_valid) begin
          m_wf[m_k*PW +: PW] = w_data;
          m_k++;
          if (m_k == NK) begin m_ph = PRun; m_n = 0; end
        end
        PRun: if (pix_valid) begin
          r = m_n / W;
          c = m_n % W;
          if (r >= KY - 1 && c >= KX - 1) begin
            e.due = cyc + P; e.r = r - (KY - 1); e.c = c - (KX - 1);
            q.push_back(e);
            m_win = 1;
          end
          if (r == KY - 1 && c == KX - 1) acc22_cyc = cyc;
          m_n++;
          if (m_n == W * H) begin m_ph = PFlush; m_f = 0; last_acc_cyc = cyc; end
        end else if (m_stall < (1 << CW) - 1) begin
          m_stall++;
        end
        PFlush: begin m_f++; if (m_f == P + 1) m_ph = PDone; end
        default: m_ph = PIdle;
      endcase
    end
    #1;
    chk("busy", busy, m_ph != PIdle);
    chk("w_ready", w_ready, m_ph == PLoad);
    chk("pix_ready", pix_ready, m_ph == PRun);
    chk("done", done, m_ph == PDone);
    chk("weights_flat", weights_flat, m_wf);
    chk("win_valid", win_valid, m_win);
    exp_rv = (q.size() > 0) && (q[0].due == cyc);
    chk("res_valid", res_valid, exp_rv);
    if (exp_rv) begin
      e = q.pop_front();
      last_r = e.r;
      last_c = e.c;
    end
    chk("res_row", res_row, last_r);
    chk("res_col", res_col, last_c);
`ifdef CONV_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    if (res_valid === 1'b1) begin
      if (obs_res == 0) begin obs_first = cyc; obs_first_r = res_row; obs_first_c = res_col; end
      obs_res++;
      obs_last_r = res_row;
      obs_last_c = res_col;
    end
    if (done === 1'b1) begin obs_done++; done_cyc = cyc; end
  endtask

  task automatic load_weights_random();
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < NK; k++) begin
      w_valid = 1'b1; w_data = PW'($urandom); pix_valid = 1'(($urandom));
      step();
      if ($urandom_range(1, 0) == 1) begin w_valid = 1'b0; step(); end
    end
    w_valid = 1'b0; pix_valid = 1'b0;
  endtask

  task automatic run_pixels(input int pct, input bit abuse);
    int guard = 0;
    while (m_ph == PRun && guard < 5000) begin
      pix_valid = ($urandom_range(99, 0) < pct);
      if (abuse) begin
        start = 1'($urandom_range(1, 0));
        w_valid = 1'($urandom_range(1, 0));
        w_data = PW'($urandom);
      end
      step();
      guard++;
    end
    pix_valid = 1'b0; start = 1'b0; w_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (m_ph != PIdle && guard < 100) begin step(); guard++; end
    chk("drain_idle", m_ph, PIdle);
  endtask

  task automatic frame_checks();
    chk("frame_results", obs_res, NOUT);
    chk("first_res_rc", {obs_first_r, obs_first_c}, {32'd0, 32'd0});
    // Edge counts: accept edge of (2,2) to the edge after which res_valid shows.
    chk("first_res_latency", obs_first - acc22_cyc, P);
    chk("last_res_rc", {obs_last_r, obs_last_c}, {32'(H - KY), 32'(W - KX)});
    chk("done_count", obs_done, 1);
    chk("done_latency", done_cyc - last_acc_cyc, P + 1);
  endtask

  typedef struct {
    bit st;
    bit wv;
    logic [PW-1:0] wd;
    bit e_busy;
    bit e_wr;
    bit e_pr;
  } vec_t;
  vec_t tbl[$];

  initial begin
    vec_t v;
    int cnt;
    logic [PW-1:0] slot;

    // Weight load table: start, then weights 1..9 with a gap cycle between them.
    v = '{st: 1, wv: 0, wd: '0, e_busy: 1, e_wr: 1, e_pr: 0};
    tbl.push_back(v);
    for (int k = 0; k < NK; k++) begin
      v = '{st: 0, wv: 1, wd: PW'(k + 1), e_busy: 1, e_wr: (k < NK - 1), e_pr: (k == NK - 1)};
      tbl.push_back(v);
      if (k < NK - 1) begin
        v = '{st: 0, wv: 0, wd: 16'hdead, e_busy: 1, e_wr: 1, e_pr: 0};
        tbl.push_back(v);
      end
    end

    model_clear();
    clear_obs();

    // Reset at time zero, then idle.
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();

    // Table-driven weight load, then a full frame with pix_valid held high.
    clear_obs();
    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].st; w_valid = tbl[i].wv; w_data = tbl[i].wd;
      step();
      chk("tbl_busy", busy, tbl[i].e_busy);
      chk("tbl_w_ready", w_ready, tbl[i].e_wr);
      chk("tbl_pix_ready", pix_ready, tbl[i].e_pr);
    end
    start = 1'b0; w_valid = 1'b0;
    for (int k = 0; k < NK; k++) begin
      slot = weights_flat[k*PW +: PW];
      chk("tbl_slot", slot, PW'(k + 1));
    end
    run_pixels(100, 0);
    drain();
    frame_checks();
    repeat (2) step();
    for (int k = 0; k < NK; k++) begin
      slot = weights_flat[k*PW +: PW];
      chk("held_slot", slot, PW'(k + 1));
    end

    // Random bubbles at 50%.
    clear_obs();
    load_weights_random();
    run_pixels(50, 0);
    drain();
    frame_checks();

    // Protocol abuse: start and w_valid toggling during RUN.
    clear_obs();
    load_weights_random();
    run_pixels(70, 1);
    drain();
    frame_checks();

    // Reset after 20 accepted pixels: abort, no further results.
    load_weights_random();
    for (int n = 0; n < 20; n++) begin pix_valid = 1'b1; step(); end
    pix_valid = 1'b0;
    step();
    rst = 1'b1;
    clear_obs();
    repeat (3) step();
    rst = 1'b0;
    pix_valid = 1'b1;
    repeat (12) step();
    pix_valid = 1'b0;
    chk("res_after_rst", obs_res, 0);
    chk("busy_after_rst", busy, 1'b0);
    chk("weights_after_rst", weights_flat, '0);

    // Clean frame after the abort.
    clear_obs();
    load_weights_random();
    run_pixels(60, 0);
    drain();
    frame_checks();

`ifdef CONV_PERF_CNT_EN
    // Exactly 10 idle RUN cycles.
    clear_obs();
    load_weights_random();
    cnt = 0;
    for (int n = 0; n < W * H; n++) begin
      if (n % 6 == 3 && cnt < 10) begin pix_valid = 1'b0; step(); cnt++; end
      pix_valid = 1'b1; step();
    end
    pix_valid = 1'b0;
    drain();
    frame_checks();
    chk("stall_after_done", stall_cnt, 16'd10);
    repeat (2) step();
    chk("stall_held", stall_cnt, 16'd10);
    start = 1'b1; step(); start = 1'b0;
    chk("stall_cleared", stall_cnt, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
